// File: rtl/vga_timing_gen_pkg.sv
// Shared video-mode constants for the VGA raster generator.
// Holds the 640x480@72 Hz defaults, the packed bundle carried by the
// sync delay line, and a couple of small decode helpers.
package vga_timing_gen_pkg;

  localparam int unsigned VM_H_ACTIVE      = 640;
  localparam int unsigned VM_H_FP          = 24;
  localparam int unsigned VM_H_SYNC        = 40;
  localparam int unsigned VM_H_BP          = 128;
  localparam int unsigned VM_V_ACTIVE      = 480;
  localparam int unsigned VM_V_FP          = 9;
  localparam int unsigned VM_V_SYNC        = 3;
  localparam int unsigned VM_V_BP          = 28;
  localparam logic        VM_H_SYNC_POL    = 1'b0;
  localparam logic        VM_V_SYNC_POL    = 1'b0;
  localparam int unsigned VM_PIPE_DELAY    = 2;
  localparam int unsigned VM_X_COORD_WIDTH = 10;
  localparam int unsigned VM_Y_COORD_WIDTH = 10;

  // Bit order matches the delay-line slice {hsync, vsync, activevideo}.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vga_sync_t;

  // True when lo <= v < hi.
  function automatic logic in_span(input int unsigned v,
                                   input int unsigned lo,
                                   input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Drive the asserted level while on, the opposite level otherwise.
  function automatic logic sync_level(input logic on, input logic pol);
    return on ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay: WIDTH x DEPTH shift register with asynchronous active-low
// reset; every stage resets to RST_VAL.
// Ports:
//   i_clk   - shift clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - value entering stage 0
//   o_q     - value leaving the last stage (i_d delayed DEPTH clocks)
module sync_delay
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from the pixel clock.
// Produces the pixel/line counters and activevideo for the renderer, plus
// hsync/vsync/de delayed by the renderer pipeline depth so the sync pins
// stay aligned with the pixel data at the board.
// Ports:
//   px_clk      - pixel clock
//   reset_n     - asynchronous active-low reset
//   x_px        - registered column counter, 0..H_TOTAL-1
//   y_px        - registered line counter, 0..V_TOTAL-1
//   activevideo - x_px/y_px inside the visible area (no delay)
//   hsync       - horizontal sync, PIPE_DELAY clocks late
//   vsync       - vertical sync, PIPE_DELAY clocks late
//   de          - activevideo, PIPE_DELAY clocks late
//   frame_tick  - one-clock pulse while the raster is at (0,0)
//   line_tick   - one-clock pulse while x_px is 0
// PIPE_DELAY must lie in 1..7.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = VM_H_ACTIVE,
  parameter int unsigned H_FP          = VM_H_FP,
  parameter int unsigned H_SYNC        = VM_H_SYNC,
  parameter int unsigned H_BP          = VM_H_BP,
  parameter int unsigned V_ACTIVE      = VM_V_ACTIVE,
  parameter int unsigned V_FP          = VM_V_FP,
  parameter int unsigned V_SYNC        = VM_V_SYNC,
  parameter int unsigned V_BP          = VM_V_BP,
  parameter logic        H_SYNC_POL    = VM_H_SYNC_POL,
  parameter logic        V_SYNC_POL    = VM_V_SYNC_POL,
  parameter int unsigned PIPE_DELAY    = VM_PIPE_DELAY,
  parameter int unsigned X_COORD_WIDTH = VM_X_COORD_WIDTH,
  parameter int unsigned Y_COORD_WIDTH = VM_Y_COORD_WIDTH
) (
  input  logic                     px_clk,
  input  logic                     reset_n,
  output logic [X_COORD_WIDTH-1:0] x_px,
  output logic [Y_COORD_WIDTH-1:0] y_px,
  output logic                     activevideo,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     de,
  output logic                     frame_tick,
  output logic                     line_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;

  localparam logic [2:0] SYNC_IDLE = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

  logic [X_COORD_WIDTH-1:0] r_x;
  logic [Y_COORD_WIDTH-1:0] r_y;
  logic [X_COORD_WIDTH-1:0] w_x_next;
  logic [Y_COORD_WIDTH-1:0] w_y_next;
  logic                     w_x_wrap;
  logic                     w_active;
  logic                     r_line_tick;
  logic                     r_frame_tick;
  vga_sync_t                w_sync_raw;
  vga_sync_t                w_sync_dly;

  // ">=" rather than "==" so a corrupted count past the end still wraps.
  assign w_x_wrap = (32'(r_x) >= H_TOTAL - 1);

  always_comb begin
    w_x_next = w_x_wrap ? '0 : r_x + X_COORD_WIDTH'(1);
    w_y_next = r_y;
    if (32'(r_y) >= V_TOTAL) begin
      w_y_next = '0;
    end else if (w_x_wrap) begin
      w_y_next = (32'(r_y) == V_TOTAL - 1) ? '0 : r_y + Y_COORD_WIDTH'(1);
    end
  end

  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      // The first cycle after release is the origin, so the tick registers
      // come out of reset already set; the output mask below keeps them
      // quiet while reset is held.
      r_line_tick  <= 1'b1;
      r_frame_tick <= 1'b1;
    end else begin
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_line_tick  <= (w_x_next == '0);
      r_frame_tick <= (w_x_next == '0) && (w_y_next == '0);
    end
  end

  assign w_active = (32'(r_x) < H_ACTIVE) && (32'(r_y) < V_ACTIVE);

  // vsync decodes only the line number, so it spans whole lines including
  // the horizontal blanking columns.
  assign w_sync_raw.hsync = sync_level(in_span(32'(r_x), HS_BEG, HS_BEG + H_SYNC),
                                       H_SYNC_POL);
  assign w_sync_raw.vsync = sync_level(in_span(32'(r_y), VS_BEG, VS_BEG + V_SYNC),
                                       V_SYNC_POL);
  assign w_sync_raw.de    = w_active;

  sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .i_clk   (px_clk),
    .i_rst_n (reset_n),
    .i_d     (w_sync_raw),
    .o_q     (w_sync_dly)
  );

  assign x_px        = r_x;
  assign y_px        = r_y;
  assign activevideo = w_active;
  assign hsync       = w_sync_dly.hsync;
  assign vsync       = w_sync_dly.vsync;
  assign de          = w_sync_dly.de;
  assign line_tick   = r_line_tick & reset_n;
  assign frame_tick  = r_frame_tick & reset_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int NI = 4;
  // Instances: 0 default (delay 2), 1 delay 1, 2 delay 7,
  // 3 reduced raster (28x13, positive syncs, delay 3) for full-frame coverage.
  localparam int HA[NI] = '{640, 640, 640, 16};
  localparam int HF[NI] = '{24, 24, 24, 3};
  localparam int HS[NI] = '{40, 40, 40, 4};
  localparam int HB[NI] = '{128, 128, 128, 5};
  localparam int VA[NI] = '{480, 480, 480, 6};
  localparam int VF[NI] = '{9, 9, 9, 2};
  localparam int VS[NI] = '{3, 3, 3, 2};
  localparam int VB[NI] = '{28, 28, 28, 3};
  localparam int HP[NI] = '{0, 0, 0, 1};
  localparam int VP[NI] = '{0, 0, 0, 1};
  localparam int PD[NI] = '{2, 1, 7, 3};

  logic clk = 1'b0;
  logic rst_n;
  logic run_chk;
  int   t;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [9:0] x_w  [NI];
  logic [9:0] y_w  [NI];
  logic       av_w [NI];
  logic       hs_w [NI];
  logic       vs_w [NI];
  logic       de_w [NI];
  logic       ft_w [NI];
  logic       lt_w [NI];

  always #5 clk = ~clk;

  vga_timing_gen #(.PIPE_DELAY(2)) u_d2 (
    .px_clk(clk), .reset_n(rst_n), .x_px(x_w[0]), .y_px(y_w[0]),
    .activevideo(av_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]), .de(de_w[0]),
    .frame_tick(ft_w[0]), .line_tick(lt_w[0]));

  vga_timing_gen #(.PIPE_DELAY(1)) u_d1 (
    .px_clk(clk), .reset_n(rst_n), .x_px(x_w[1]), .y_px(y_w[1]),
    .activevideo(av_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]), .de(de_w[1]),
    .frame_tick(ft_w[1]), .line_tick(lt_w[1]));

  vga_timing_gen #(.PIPE_DELAY(7)) u_d7 (
    .px_clk(clk), .reset_n(rst_n), .x_px(x_w[2]), .y_px(y_w[2]),
    .activevideo(av_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]), .de(de_w[2]),
    .frame_tick(ft_w[2]), .line_tick(lt_w[2]));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIPE_DELAY(3)
  ) u_sm (
    .px_clk(clk), .reset_n(rst_n), .x_px(x_w[3]), .y_px(y_w[3]),
    .activevideo(av_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]), .de(de_w[3]),
    .frame_tick(ft_w[3]), .line_tick(lt_w[3]));

  // Clocks elapsed since reset release; the raster position is a pure
  // function of this count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  function automatic void model(input int i, input int tt, input bit in_rst,
                                output int ex, output int ey, output int eav,
                                output int ehs, output int evs, output int ede,
                                output int eft, output int elt);
    int ht, vt, d, dx, dy;
    ht  = HA[i] + HF[i] + HS[i] + HB[i];
    vt  = VA[i] + VF[i] + VS[i] + VB[i];
    ehs = 1 - HP[i];
    evs = 1 - VP[i];
    ede = 0;
    if (in_rst) begin
      ex = 0; ey = 0; eav = 1; eft = 0; elt = 0;
    end else begin
      ex  = tt % ht;
      ey  = (tt / ht) % vt;
      eav = (ex < HA[i] && ey < VA[i]) ? 1 : 0;
      elt = (ex == 0) ? 1 : 0;
      eft = (ex == 0 && ey == 0) ? 1 : 0;
      if (tt >= PD[i]) begin
        d  = tt - PD[i];
        dx = d % ht;
        dy = (d / ht) % vt;
        if (dx >= HA[i] + HF[i] && dx < HA[i] + HF[i] + HS[i]) ehs = HP[i];
        if (dy >= VA[i] + VF[i] && dy < VA[i] + VF[i] + VS[i]) evs = VP[i];
        ede = (dx < HA[i] && dy < VA[i]) ? 1 : 0;
      end
    end
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0d got %0d expected %0d", nm, i, t, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input bit in_rst);
    int ex, ey, eav, ehs, evs, ede, eft, elt;
    model(i, t, in_rst, ex, ey, eav, ehs, evs, ede, eft, elt);
    chk("x_px",        i, int'(x_w[i]),  ex);
    chk("y_px",        i, int'(y_w[i]),  ey);
    chk("activevideo", i, int'(av_w[i]), eav);
    chk("hsync",       i, int'(hs_w[i]), ehs);
    chk("vsync",       i, int'(vs_w[i]), evs);
    chk("de",          i, int'(de_w[i]), ede);
    chk("frame_tick",  i, int'(ft_w[i]), eft);
    chk("line_tick",   i, int'(lt_w[i]), elt);
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < NI; i++) check_inst(i, !rst_n);
      if (rst_n) begin
        if (t == 1)   chk("pin_de_rise_pre", 0, int'(de_w[0]), 0);
        if (t == 2)   chk("pin_de_rise",     0, int'(de_w[0]), 1);
        if (t == 641) chk("pin_de_fall_pre", 0, int'(de_w[0]), 1);
        if (t == 642) chk("pin_de_fall",     0, int'(de_w[0]), 0);
        if (t == 665) chk("pin_hs_d2_pre",   0, int'(hs_w[0]), 1);
        if (t == 666) chk("pin_hs_d2_fall",  0, int'(hs_w[0]), 0);
        if (t == 664) chk("pin_hs_d1_pre",   1, int'(hs_w[1]), 1);
        if (t == 665) chk("pin_hs_d1_fall",  1, int'(hs_w[1]), 0);
        if (t == 670) chk("pin_hs_d7_pre",   2, int'(hs_w[2]), 1);
        if (t == 671) chk("pin_hs_d7_fall",  2, int'(hs_w[2]), 0);
        if (t == 705) chk("pin_hs_d2_rise",  0, int'(hs_w[0]), 0);
        if (t == 706) chk("pin_hs_d2_end",   0, int'(hs_w[0]), 1);
        if (t == 831) chk("pin_lt_831",      0, int'(lt_w[0]), 0);
        if (t == 832) begin
          chk("pin_wrap_x",  0, int'(x_w[0]),  0);
          chk("pin_wrap_y",  0, int'(y_w[0]),  1);
          chk("pin_wrap_lt", 0, int'(lt_w[0]), 1);
          chk("pin_wrap_ft", 0, int'(ft_w[0]), 0);
        end
        if (t == 3)   chk("pin_sm_de_rise", 3, int'(de_w[3]), 1);
        if (t == 226) chk("pin_sm_vs_pre",  3, int'(vs_w[3]), 0);
        if (t == 227) chk("pin_sm_vs_on",   3, int'(vs_w[3]), 1);
        if (t == 363) chk("pin_sm_last_y",  3, int'(y_w[3]),  12);
        if (t == 364) begin
          chk("pin_sm_frame_ft", 3, int'(ft_w[3]), 1);
          chk("pin_sm_frame_y",  3, int'(y_w[3]),  0);
        end
      end
    end
  end

  initial begin
    int hold;
    rst_n   = 1'b1;
    run_chk = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    run_chk = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check_inst(i, 1'b0);
    chk("rel_ft", 0, int'(ft_w[0]), 1);
    chk("rel_lt", 0, int'(lt_w[0]), 1);
    chk("rel_hs", 0, int'(hs_w[0]), 1);
    chk("rel_vs", 0, int'(vs_w[0]), 1);
    chk("rel_de", 0, int'(de_w[0]), 0);
    repeat (1800) @(posedge clk);

    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) check_inst(i, 1'b1);
      hold = $urandom_range(1, 3);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) check_inst(i, 1'b0);
      chk("rel_ft_sm", 3, int'(ft_w[3]), 1);
      hold = $urandom_range(100, 1500);
      repeat (hold) @(posedge clk);
    end

    @(negedge clk);
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
